// File: rtl/mips_pkg.sv
// Shared encodings for the EX stage: R-type funct codes, ALU operation classes
// and the state type of the iterative multiply unit.
package mips_pkg;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef enum logic [1:0] {
        LIBRE   = 2'd0,
        OCUPADO = 2'd1,
        FIN     = 2'd2
    } mdu_estado_t;

    function automatic logic es_multiplicacion(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    endfunction

    function automatic logic es_mover_hilo(input logic [5:0] funct);
        return (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);
    endfunction

endpackage

// File: rtl/mdu_iterativo.sv
// Iterative radix-2 shift-add multiplier holding HI/LO. Signed products are
// formed from operand magnitudes and negated once at the end.
module mdu_iterativo
    import mips_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic             firmado,
    input  logic [ANCHO-1:0] op_a,
    input  logic [ANCHO-1:0] op_b,
    output mdu_estado_t      estado,
    output logic [ANCHO-1:0] hi,
    output logic [ANCHO-1:0] lo
);

    localparam int CNT_W = $clog2(ANCHO) + 1;

    mdu_estado_t        estado_q, estado_d;
    logic [CNT_W-1:0]   cuenta_q, cuenta_d;
    logic [ANCHO-1:0]   mcand_q, mcand_d;
    logic [2*ANCHO-1:0] prod_q, prod_d;
    logic               negar_q, negar_d;
    logic [ANCHO-1:0]   hi_q, hi_d;
    logic [ANCHO-1:0]   lo_q, lo_d;

    logic [ANCHO-1:0]   mag_a;
    logic [ANCHO-1:0]   mag_b;
    logic [ANCHO:0]     suma;
    logic [2*ANCHO-1:0] prod_final;

    always_comb begin
        mag_a = (firmado && op_a[ANCHO-1]) ? (~op_a + 1'b1) : op_a;
        mag_b = (firmado && op_b[ANCHO-1]) ? (~op_b + 1'b1) : op_b;
        suma  = {1'b0, prod_q[2*ANCHO-1:ANCHO]} +
                (prod_q[0] ? {1'b0, mcand_q} : {(ANCHO+1){1'b0}});
        prod_final = negar_q ? (~prod_q + 1'b1) : prod_q;
    end

    // LO half of prod_q starts as the multiplier and is shifted out one bit per step
    always_comb begin
        estado_d = estado_q;
        cuenta_d = cuenta_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        negar_d  = negar_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (estado_q)
            LIBRE: begin
                if (inicio) begin
                    mcand_d  = mag_a;
                    prod_d   = {{ANCHO{1'b0}}, mag_b};
                    negar_d  = firmado && (op_a[ANCHO-1] ^ op_b[ANCHO-1]);
                    cuenta_d = '0;
                    estado_d = OCUPADO;
                end
            end
            OCUPADO: begin
                prod_d   = {suma, prod_q[ANCHO-1:1]};
                cuenta_d = cuenta_q + CNT_W'(1);
                if (cuenta_q == CNT_W'(ANCHO - 1)) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                {hi_d, lo_d} = prod_final;
                estado_d     = LIBRE;
            end
            default: estado_d = LIBRE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= LIBRE;
            cuenta_q <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            negar_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            estado_q <= estado_d;
            cuenta_q <= cuenta_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            negar_q  <= negar_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign estado = estado_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: rtl/exe_multiciclo.sv
// Execute stage: operand bypass, ALU, branch resolution, iterative multiplier
// and the EX/MEM pipeline register.
module exe_multiciclo
    import mips_pkg::*;
#(
    parameter int ANCHO      = 32,
    parameter int REG_BITS   = 5,
    parameter int FORWARDING = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ANCHO-1:0]    pc_plus4_EX,
    input  logic [ANCHO-1:0]    dr1_EX,
    input  logic [ANCHO-1:0]    dr2_EX,
    input  logic [ANCHO-1:0]    inmediato_ext_EX,
    input  logic [REG_BITS-1:0] rs_EX,
    input  logic [REG_BITS-1:0] rt_EX,
    input  logic [REG_BITS-1:0] rd_EX,
    input  logic [5:0]          funct_EX,
    input  logic                reg_escribir_EX,
    input  logic                mem_a_reg_EX,
    input  logic                mem_escribir_EX,
    input  logic                mem_leer_EX,
    input  logic                branch_EX,
    input  logic                alu_fuente_EX,
    input  logic [1:0]          alu_operacion_EX,
    input  logic                valido_EX,
    input  logic [ANCHO-1:0]    dato_MEM,
    input  logic [ANCHO-1:0]    dato_WB,
    input  logic [REG_BITS-1:0] rd_MEM,
    input  logic [REG_BITS-1:0] rd_WB,
    input  logic                reg_escribir_MEM,
    input  logic                reg_escribir_WB,
    input  logic                stall_mem,
    input  logic                flush,
    output logic                stall_ex,
    output logic [ANCHO-1:0]    resultado_alu_MEM,
    output logic [ANCHO-1:0]    dr2_MEM,
    output logic [ANCHO-1:0]    branch_target_MEM,
    output logic [REG_BITS-1:0] registro_destino_MEM,
    output logic                branch_habilitado_MEM,
    output logic                reg_escribir_MEM_ctrl,
    output logic                mem_a_reg_MEM_ctrl,
    output logic                mem_escribir_MEM_ctrl,
    output logic                mem_leer_MEM_ctrl
);

    logic [ANCHO-1:0]    op_a;
    logic [ANCHO-1:0]    op_b;
    logic [ANCHO-1:0]    alu_b;
    logic [ANCHO-1:0]    resultado;
    logic [ANCHO-1:0]    diferencia;
    logic [ANCHO-1:0]    branch_target;
    logic [REG_BITS-1:0] destino;
    logic                es_mult_ex;
    logic                es_mfhilo_ex;
    logic                mdu_inicio;
    mdu_estado_t         mdu_estado;
    logic [ANCHO-1:0]    mdu_hi;
    logic [ANCHO-1:0]    mdu_lo;

    logic [ANCHO-1:0]    res_q, res_d;
    logic [ANCHO-1:0]    dr2_q, dr2_d;
    logic [ANCHO-1:0]    bt_q, bt_d;
    logic [REG_BITS-1:0] dest_q, dest_d;
    logic                br_q, br_d;
    logic                rw_q, rw_d;
    logic                m2r_q, m2r_d;
    logic                mw_q, mw_d;
    logic                mr_q, mr_d;

    // MEM is the younger producer, so it wins over WB; register 0 is never forwarded
    always_comb begin
        op_a = dr1_EX;
        op_b = dr2_EX;
        if (FORWARDING != 0) begin
            if (reg_escribir_MEM && (rd_MEM != '0) && (rd_MEM == rs_EX)) begin
                op_a = dato_MEM;
            end else if (reg_escribir_WB && (rd_WB != '0) && (rd_WB == rs_EX)) begin
                op_a = dato_WB;
            end
            if (reg_escribir_MEM && (rd_MEM != '0) && (rd_MEM == rt_EX)) begin
                op_b = dato_MEM;
            end else if (reg_escribir_WB && (rd_WB != '0) && (rd_WB == rt_EX)) begin
                op_b = dato_WB;
            end
        end
    end

    always_comb begin
        alu_b     = alu_fuente_EX ? inmediato_ext_EX : op_b;
        resultado = '0;
        case (alu_operacion_EX)
            ALU_OP_ADD: resultado = op_a + alu_b;
            ALU_OP_SUB: resultado = op_a - alu_b;
            ALU_OP_FUNCT: begin
                case (funct_EX)
                    FUNCT_ADD: resultado = op_a + alu_b;
                    FUNCT_SUB: resultado = op_a - alu_b;
                    FUNCT_AND: resultado = op_a & alu_b;
                    FUNCT_OR:  resultado = op_a | alu_b;
                    FUNCT_NOR: resultado = ~(op_a | alu_b);
                    FUNCT_SLT: resultado = {{(ANCHO-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
                    FUNCT_MFHI: resultado = mdu_hi;
                    FUNCT_MFLO: resultado = mdu_lo;
                    default:   resultado = '0;
                endcase
            end
            default: resultado = '0;
        endcase
    end

    always_comb begin
        diferencia    = op_a - alu_b;
        branch_target = pc_plus4_EX + {inmediato_ext_EX[ANCHO-3:0], 2'b00};
        es_mult_ex    = (alu_operacion_EX == ALU_OP_FUNCT) && es_multiplicacion(funct_EX);
        es_mfhilo_ex  = valido_EX && (alu_operacion_EX == ALU_OP_FUNCT) && es_mover_hilo(funct_EX);
        destino       = (alu_operacion_EX == ALU_OP_FUNCT) ? rd_EX : rt_EX;
        if (es_mult_ex) begin
            destino = '0;
        end
        // A held (stall_mem) or squashed issue must not start, or the mult would run twice
        mdu_inicio = valido_EX && es_mult_ex && (mdu_estado == LIBRE) && !flush && !stall_mem;
        stall_ex   = (mdu_estado == OCUPADO) || (mdu_estado == FIN) ||
                     (es_mfhilo_ex && (mdu_estado != LIBRE));
    end

    mdu_iterativo #(
        .ANCHO (ANCHO)
    ) u_mdu (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (mdu_inicio),
        .firmado (funct_EX == FUNCT_MULT),
        .op_a    (op_a),
        .op_b    (op_b),
        .estado  (mdu_estado),
        .hi      (mdu_hi),
        .lo      (mdu_lo)
    );

    // Mult writes no GPR, so its slot leaves EX as a bubble
    always_comb begin
        res_d  = res_q;
        dr2_d  = dr2_q;
        bt_d   = bt_q;
        dest_d = dest_q;
        br_d   = br_q;
        rw_d   = rw_q;
        m2r_d  = m2r_q;
        mw_d   = mw_q;
        mr_d   = mr_q;
        if (!stall_mem) begin
            if (flush) begin
                br_d  = 1'b0;
                rw_d  = 1'b0;
                m2r_d = 1'b0;
                mw_d  = 1'b0;
                mr_d  = 1'b0;
            end else if (!stall_ex) begin
                res_d  = resultado;
                dr2_d  = op_b;
                bt_d   = branch_target;
                dest_d = destino;
                br_d   = !es_mult_ex && branch_EX && (diferencia == '0);
                rw_d   = !es_mult_ex && reg_escribir_EX;
                m2r_d  = !es_mult_ex && mem_a_reg_EX;
                mw_d   = !es_mult_ex && mem_escribir_EX;
                mr_d   = !es_mult_ex && mem_leer_EX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            dr2_q  <= '0;
            bt_q   <= '0;
            dest_q <= '0;
            br_q   <= 1'b0;
            rw_q   <= 1'b0;
            m2r_q  <= 1'b0;
            mw_q   <= 1'b0;
            mr_q   <= 1'b0;
        end else begin
            res_q  <= res_d;
            dr2_q  <= dr2_d;
            bt_q   <= bt_d;
            dest_q <= dest_d;
            br_q   <= br_d;
            rw_q   <= rw_d;
            m2r_q  <= m2r_d;
            mw_q   <= mw_d;
            mr_q   <= mr_d;
        end
    end

    assign resultado_alu_MEM     = res_q;
    assign dr2_MEM               = dr2_q;
    assign branch_target_MEM     = bt_q;
    assign registro_destino_MEM  = dest_q;
    assign branch_habilitado_MEM = br_q;
    assign reg_escribir_MEM_ctrl = rw_q;
    assign mem_a_reg_MEM_ctrl    = m2r_q;
    assign mem_escribir_MEM_ctrl = mw_q;
    assign mem_leer_MEM_ctrl     = mr_q;

endmodule

// File: tb/tb_exe_multiciclo.sv
// Self-checking bench for exe_multiciclo: scoreboard of expected EX/MEM contents,
// one task per scenario.
module tb_exe_multiciclo;
    import mips_pkg::*;

    localparam int W  = 32;
    localparam int RB = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  pc_plus4_EX, dr1_EX, dr2_EX, inmediato_ext_EX;
    logic [RB-1:0] rs_EX, rt_EX, rd_EX;
    logic [5:0]    funct_EX;
    logic          reg_escribir_EX, mem_a_reg_EX, mem_escribir_EX, mem_leer_EX;
    logic          branch_EX, alu_fuente_EX;
    logic [1:0]    alu_operacion_EX;
    logic          valido_EX;
    logic [W-1:0]  dato_MEM, dato_WB;
    logic [RB-1:0] rd_MEM, rd_WB;
    logic          reg_escribir_MEM, reg_escribir_WB;
    logic          stall_mem, flush;
    logic          stall_ex;
    logic [W-1:0]  resultado_alu_MEM, dr2_MEM, branch_target_MEM;
    logic [RB-1:0] registro_destino_MEM;
    logic          branch_habilitado_MEM, reg_escribir_MEM_ctrl, mem_a_reg_MEM_ctrl;
    logic          mem_escribir_MEM_ctrl, mem_leer_MEM_ctrl;
    logic [4:0]    ctrl_obs;

    exe_multiciclo #(.ANCHO(W), .REG_BITS(RB), .FORWARDING(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pc_plus4_EX(pc_plus4_EX), .dr1_EX(dr1_EX), .dr2_EX(dr2_EX),
        .inmediato_ext_EX(inmediato_ext_EX),
        .rs_EX(rs_EX), .rt_EX(rt_EX), .rd_EX(rd_EX), .funct_EX(funct_EX),
        .reg_escribir_EX(reg_escribir_EX), .mem_a_reg_EX(mem_a_reg_EX),
        .mem_escribir_EX(mem_escribir_EX), .mem_leer_EX(mem_leer_EX),
        .branch_EX(branch_EX), .alu_fuente_EX(alu_fuente_EX),
        .alu_operacion_EX(alu_operacion_EX), .valido_EX(valido_EX),
        .dato_MEM(dato_MEM), .dato_WB(dato_WB), .rd_MEM(rd_MEM), .rd_WB(rd_WB),
        .reg_escribir_MEM(reg_escribir_MEM), .reg_escribir_WB(reg_escribir_WB),
        .stall_mem(stall_mem), .flush(flush), .stall_ex(stall_ex),
        .resultado_alu_MEM(resultado_alu_MEM), .dr2_MEM(dr2_MEM),
        .branch_target_MEM(branch_target_MEM),
        .registro_destino_MEM(registro_destino_MEM),
        .branch_habilitado_MEM(branch_habilitado_MEM),
        .reg_escribir_MEM_ctrl(reg_escribir_MEM_ctrl),
        .mem_a_reg_MEM_ctrl(mem_a_reg_MEM_ctrl),
        .mem_escribir_MEM_ctrl(mem_escribir_MEM_ctrl),
        .mem_leer_MEM_ctrl(mem_leer_MEM_ctrl)
    );

    always #5 clk = ~clk;

    assign ctrl_obs = {branch_habilitado_MEM, reg_escribir_MEM_ctrl, mem_a_reg_MEM_ctrl,
                       mem_escribir_MEM_ctrl, mem_leer_MEM_ctrl};

    typedef struct {
        logic [W-1:0]  res;
        logic [W-1:0]  dr2;
        logic [RB-1:0] dest;
        logic [4:0]    ctrl;
    } esperado_t;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        fuente;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] imm;
        logic [3:0]  mem_ctl;
        logic [W-1:0] res;
        logic [RB-1:0] dest;
        logic [4:0]  ctrl;
    } stim_t;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } mdu_caso_t;

    esperado_t sb[$];
    esperado_t e;
    int n_total = 0;
    int n_pass  = 0;

    task automatic limpiar();
        pc_plus4_EX = '0; dr1_EX = '0; dr2_EX = '0; inmediato_ext_EX = '0;
        rs_EX = '0; rt_EX = '0; rd_EX = '0; funct_EX = '0;
        reg_escribir_EX = 0; mem_a_reg_EX = 0; mem_escribir_EX = 0; mem_leer_EX = 0;
        branch_EX = 0; alu_fuente_EX = 0; alu_operacion_EX = 2'b00; valido_EX = 0;
        dato_MEM = '0; dato_WB = '0; rd_MEM = '0; rd_WB = '0;
        reg_escribir_MEM = 0; reg_escribir_WB = 0; stall_mem = 0; flush = 0;
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_funct(input logic [5:0] f, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [RB-1:0] rd);
        alu_operacion_EX = ALU_OP_FUNCT; funct_EX = f; alu_fuente_EX = 0;
        dr1_EX = a; dr2_EX = b; rs_EX = 5'd1; rt_EX = 5'd3; rd_EX = rd;
        reg_escribir_EX = 1; valido_EX = 1;
    endtask

    task automatic test_reset();
        limpiar();
        #2 rst_n = 0;
        #2;
        n_total++;
        if (ctrl_obs !== 5'b0 || stall_ex !== 1'b0) $display("[TB] FAIL reset_ctrl got ctrl=%b stall=%b want 00000/0", ctrl_obs, stall_ex);
        else n_pass++;
        n_total++;
        if ({resultado_alu_MEM, dr2_MEM, branch_target_MEM, registro_destino_MEM} !== '0)
            $display("[TB] FAIL reset_data got res=%h dr2=%h bt=%h dest=%0d want all 0",
                     resultado_alu_MEM, dr2_MEM, branch_target_MEM, registro_destino_MEM);
        else n_pass++;
        @(negedge clk) rst_n = 1;
        ciclo();
    endtask

    task automatic test_bypass();
        limpiar();
        alu_operacion_EX = ALU_OP_ADD; alu_fuente_EX = 1; inmediato_ext_EX = 32'd1;
        rs_EX = 5'd5; rt_EX = 5'd5; dr1_EX = 32'hAAAA; dr2_EX = 32'hBBBB;
        reg_escribir_EX = 1; valido_EX = 1;
        rd_MEM = 5'd5; rd_WB = 5'd5; dato_MEM = 32'h11; dato_WB = 32'h22;
        reg_escribir_MEM = 1; reg_escribir_WB = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) rd_MEM = 5'd0;
            if (i == 2) reg_escribir_WB = 0;
            case (i)
                0: sb.push_back('{32'h12, 32'h11, 5'd5, 5'b01000});
                1: sb.push_back('{32'h23, 32'h22, 5'd5, 5'b01000});
                default: sb.push_back('{32'hAAAB, 32'hBBBB, 5'd5, 5'b01000});
            endcase
            ciclo();
            e = sb.pop_front();
            n_total++;
            if (resultado_alu_MEM !== e.res || dr2_MEM !== e.dr2)
                $display("[TB] FAIL bypass_%0d got res=%h dr2=%h want res=%h dr2=%h",
                         i, resultado_alu_MEM, dr2_MEM, e.res, e.dr2);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        limpiar();
        t.push_back('{ALU_OP_FUNCT, FUNCT_ADD, 1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'h00E01333, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_SUB, 1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'hE1001135, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_AND, 1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'h00F00034, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_OR,  1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'hFFF012FF, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_NOR, 1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'h000FED00, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_SLT, 1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'h00000001, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, FUNCT_SLT, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h0, 4'b0000, 32'h00000000, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_FUNCT, 6'h3F,     1'b0, 32'hF0F01234, 32'h0FF000FF, 32'h0, 4'b0000, 32'h00000000, 5'd9, 5'b01000});
        t.push_back('{ALU_OP_SUB,   6'h00,     1'b1, 32'h00000010, 32'h0, 32'h11, 4'b0000, 32'hFFFFFFFF, 5'd3, 5'b01000});
        t.push_back('{ALU_OP_ADD,   6'h00,     1'b1, 32'h00001000, 32'h0, 32'h20, 4'b1101, 32'h00001020, 5'd3, 5'b01101});
        t.push_back('{ALU_OP_ADD,   6'h00,     1'b1, 32'h00002000, 32'h0, 32'hFFFFFFFC, 4'b0010, 32'h00001FFC, 5'd3, 5'b00010});
        for (int i = 0; i < t.size(); i++) begin
            alu_operacion_EX = t[i].op; funct_EX = t[i].funct; alu_fuente_EX = t[i].fuente;
            dr1_EX = t[i].a; dr2_EX = t[i].b; inmediato_ext_EX = t[i].imm;
            rs_EX = 5'd1; rt_EX = 5'd3; rd_EX = 5'd9; valido_EX = 1;
            {reg_escribir_EX, mem_a_reg_EX, mem_escribir_EX, mem_leer_EX} = t[i].mem_ctl;
            if (t[i].op != ALU_OP_FUNCT && t[i].mem_ctl == 4'b0000) reg_escribir_EX = 1;
            if (t[i].op == ALU_OP_FUNCT) reg_escribir_EX = 1;
            sb.push_back('{t[i].res, 32'h0, t[i].dest, t[i].ctrl});
            ciclo();
            e = sb.pop_front();
            n_total++;
            if (resultado_alu_MEM !== e.res || registro_destino_MEM !== e.dest || ctrl_obs !== e.ctrl)
                $display("[TB] FAIL alu_%0d got res=%h dest=%0d ctrl=%b want res=%h dest=%0d ctrl=%b",
                         i, resultado_alu_MEM, registro_destino_MEM, ctrl_obs, e.res, e.dest, e.ctrl);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        limpiar();
        pc_plus4_EX = 32'h100; inmediato_ext_EX = 32'hFFFFFFFF; dr1_EX = 32'd9; dr2_EX = 32'd9;
        alu_operacion_EX = ALU_OP_SUB; branch_EX = 1; valido_EX = 1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            if (i == 2) dr2_EX = 32'd8;
            sb.push_back('{32'h0, 32'h0, 5'd0, (i == 0) ? 5'b10000 : 5'b00000});
            ciclo();
            e = sb.pop_front();
            n_total++;
            if (ctrl_obs !== e.ctrl)
                $display("[TB] FAIL branch_ctrl_%0d got %b want %b", i, ctrl_obs, e.ctrl);
            else n_pass++;
            if (i != 1) begin
                n_total++;
                if (branch_target_MEM !== 32'hFC)
                    $display("[TB] FAIL branch_target_%0d got %h want 000000fc", i, branch_target_MEM);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stall_mem();
        limpiar();
        alu_operacion_EX = ALU_OP_ADD; alu_fuente_EX = 1; valido_EX = 1; reg_escribir_EX = 1;
        dr1_EX = 32'h40; inmediato_ext_EX = 32'h2; rt_EX = 5'd4;
        ciclo();
        dr1_EX = 32'h50; inmediato_ext_EX = 32'h5; rt_EX = 5'd6; stall_mem = 1;
        sb.push_back('{32'h55, 32'h0, 5'd6, 5'b01000});
        for (int i = 0; i < 3; i++) begin
            ciclo();
            n_total++;
            if (resultado_alu_MEM !== 32'h42 || registro_destino_MEM !== 5'd4)
                $display("[TB] FAIL stall_mem_hold_%0d got res=%h dest=%0d want 00000042/4",
                         i, resultado_alu_MEM, registro_destino_MEM);
            else n_pass++;
        end
        stall_mem = 0;
        ciclo();
        e = sb.pop_front();
        n_total++;
        if (resultado_alu_MEM !== e.res || registro_destino_MEM !== e.dest)
            $display("[TB] FAIL stall_mem_release got res=%h dest=%0d want %h/%0d",
                     resultado_alu_MEM, registro_destino_MEM, e.res, e.dest);
        else n_pass++;
    endtask

    task automatic test_flush_issue();
        limpiar();
        drive_funct(FUNCT_MULTU, 32'd5, 32'd6, 5'd0);
        flush = 1;
        ciclo();
        limpiar();
        ciclo();
        n_total++;
        if (stall_ex !== 1'b0) $display("[TB] FAIL flush_issue got stall_ex=%b want 0", stall_ex);
        else n_pass++;
    endtask

    task automatic test_mdu();
        mdu_caso_t c[$];
        int n;
        logic temprano;
        c.push_back('{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        c.push_back('{FUNCT_MULT,  32'hFFFFFFFD, 32'hFFFFFFF9, 32'h00000000, 32'h00000015});
        c.push_back('{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB});
        for (int i = 0; i < c.size(); i++) begin
            limpiar();
            drive_funct(c[i].funct, c[i].a, c[i].b, 5'd7);
            ciclo();
            n_total++;
            if (ctrl_obs !== 5'b0 || registro_destino_MEM !== 5'd0)
                $display("[TB] FAIL mult_bubble_%0d got ctrl=%b dest=%0d want 00000/0", i, ctrl_obs, registro_destino_MEM);
            else n_pass++;
            drive_funct(FUNCT_MFHI, 32'h0, 32'h0, 5'd10);
            sb.push_back('{c[i].hi, 32'h0, 5'd10, 5'b01000});
            n = 0;
            temprano = 0;
            while (stall_ex === 1'b1 && n < 100) begin
                n++;
                if (reg_escribir_MEM_ctrl !== 1'b0) temprano = 1;
                ciclo();
            end
            n_total++;
            if (n != 33 || temprano)
                $display("[TB] FAIL mdu_stall_%0d got %0d stall cycles early=%b want 33/0", i, n, temprano);
            else n_pass++;
            ciclo();
            e = sb.pop_front();
            n_total++;
            if (resultado_alu_MEM !== e.res || registro_destino_MEM !== e.dest || ctrl_obs !== e.ctrl)
                $display("[TB] FAIL mfhi_%0d got %h dest=%0d ctrl=%b want %h", i, resultado_alu_MEM,
                         registro_destino_MEM, ctrl_obs, e.res);
            else n_pass++;
            drive_funct(FUNCT_MFLO, 32'h0, 32'h0, 5'd11);
            sb.push_back('{c[i].lo, 32'h0, 5'd11, 5'b01000});
            ciclo();
            e = sb.pop_front();
            n_total++;
            if (resultado_alu_MEM !== e.res || registro_destino_MEM !== e.dest)
                $display("[TB] FAIL mflo_%0d got %h dest=%0d want %h", i, resultado_alu_MEM,
                         registro_destino_MEM, e.res);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_mult();
        limpiar();
        drive_funct(FUNCT_MULTU, 32'h1234, 32'h10, 5'd0);
        ciclo();
        limpiar();
        repeat (8) ciclo();
        n_total++;
        if (stall_ex !== 1'b1) $display("[TB] FAIL mid_mult_busy got stall_ex=%b want 1", stall_ex);
        else n_pass++;
        ciclo();
        rst_n = 0;
        #1;
        n_total++;
        if (stall_ex !== 1'b0 || ctrl_obs !== 5'b0)
            $display("[TB] FAIL mid_mult_reset got stall=%b ctrl=%b want 0/00000", stall_ex, ctrl_obs);
        else n_pass++;
        #2 rst_n = 1;
        drive_funct(FUNCT_MFHI, 32'h0, 32'h0, 5'd12);
        #1;
        n_total++;
        if (stall_ex !== 1'b0) $display("[TB] FAIL mid_mult_libre got stall_ex=%b want 0", stall_ex);
        else n_pass++;
        sb.push_back('{32'h0, 32'h0, 5'd12, 5'b01000});
        ciclo();
        e = sb.pop_front();
        n_total++;
        if (resultado_alu_MEM !== e.res || ctrl_obs !== e.ctrl)
            $display("[TB] FAIL mid_mult_hi got %h ctrl=%b want %h", resultado_alu_MEM, ctrl_obs, e.res);
        else n_pass++;
        drive_funct(FUNCT_MFLO, 32'h0, 32'h0, 5'd12);
        sb.push_back('{32'h0, 32'h0, 5'd12, 5'b01000});
        ciclo();
        e = sb.pop_front();
        n_total++;
        if (resultado_alu_MEM !== e.res || stall_ex !== 1'b0)
            $display("[TB] FAIL mid_mult_lo got %h stall=%b want %h/0", resultado_alu_MEM, stall_ex, e.res);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_back_to_back();
        test_branch();
        test_stall_mem();
        test_flush_issue();
        test_mdu();
        test_reset_mid_mult();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
